bytes_to_bits_stream: RTL and testbench

Streaming inverse of the combinational bit-packer: accepts a frame of `BYTE_LENGTH` bytes over a valid/ready byte interface and emits the same frame as an LSB-first bit stream, `OUT_W` bits per transfer. Within the frame, bit k of the output stream is bit (k mod 8) of byte ⌊k/8⌋. It sits between the PRF/XOF byte output and the CBD sampler and decompression stages, which consume fixed-width bit groups.

---
 rtl/kyber_stream_pkg.sv | 19 +
 rtl/bytes_to_bits_stream_if.sv | 26 ++
 rtl/bytes_to_bits_stream_bit_accumulator.sv | 59 +++++
 rtl/bytes_to_bits_stream.sv | 99 +++++++++
 tb/tb_bytes_to_bits_stream.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/kyber_stream_pkg.sv
// Shared types and constants for the Kyber byte/bit streaming blocks.
// Provides: the stream FSM state enum, the default frame length, and an
// elaboration-time legality check for the output group width.
package kyber_stream_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DEFAULT_BYTE_LENGTH = 32;

  // Group width must be 1..8 and must tile the frame exactly.
  function automatic bit out_w_legal(input int out_w, input int byte_length);
    return (out_w >= 1) && (out_w <= 8) && (byte_length >= 1) &&
           (((8 * byte_length) % out_w) == 0);
  endfunction

endpackage

// File: rtl/bytes_to_bits_stream_if.sv
// Byte-in / bit-group-out streaming bus with valid/ready on both sides.
// in_byte/in_valid/in_ready: byte sink; out_bits/out_valid/out_ready/out_last:
// group source. slave = the converter, master = the producer/consumer side.
interface bytes_to_bits_stream_if #(
  parameter int OUT_W = 1
) ();

  logic [7:0]       in_byte;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_bits;
  logic             out_valid;
  logic             out_ready;
  logic             out_last;

  modport slave (
    input  in_byte, in_valid, out_ready,
    output in_ready, out_bits, out_valid, out_last
  );

  modport master (
    output in_byte, in_valid, out_ready,
    input  in_ready, out_bits, out_valid, out_last
  );

endinterface

// File: rtl/bytes_to_bits_stream_bit_accumulator.sv
// 16-bit LSB-first bit accumulator: shift out OUT_W bits, then insert a byte at cnt.
// Latency: an inserted byte is visible on out_bits the cycle after insertion.
// Backpressure: none internally; the caller gates in_fire (cnt <= 8) and out_fire (cnt >= OUT_W).
// Ports: clk, rst_n, clear (synchronous flush), in_fire/in_byte, out_fire,
//        out_bits (low OUT_W bits of acc), cnt (number of valid bits, 0..16).
module bit_accumulator #(
  parameter int OUT_W = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_fire,
  input  logic [7:0]       in_byte,
  input  logic             out_fire,
  output logic [OUT_W-1:0] out_bits,
  output logic [4:0]       cnt
);

  localparam logic [4:0] W5 = 5'(OUT_W);

  logic [15:0] acc;
  logic [15:0] acc_s;
  logic [15:0] acc_n;
  logic [4:0]  cnt_s;
  logic [4:0]  cnt_n;

  // Shift first, then insert at the post-shift fill level, so a byte taken in
  // the same cycle as a group lands directly behind the surviving bits.
  always_comb begin
    acc_s = acc;
    cnt_s = cnt;
    if (out_fire) begin
      acc_s = acc >> OUT_W;
      cnt_s = cnt - W5;
    end
    acc_n = acc_s;
    cnt_n = cnt_s;
    if (in_fire) begin
      acc_n = (acc_s & ~(16'h00FF << cnt_s)) | ({8'h00, in_byte} << cnt_s);
      cnt_n = cnt_s + 5'd8;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (clear) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      acc <= acc_n;
      cnt <= cnt_n;
    end
  end

  assign out_bits = acc[OUT_W-1:0];

endmodule

// File: rtl/bytes_to_bits_stream.sv
// Converts a BYTE_LENGTH-byte frame into an LSB-first stream of OUT_W-bit groups.
// Latency: start -> in_ready next cycle; first group one cycle after the first byte.
// Backpressure: in_ready/out_valid decode registered state only; bytes stall while cnt > 8.
// Ports: clk, rst_n (async, active-low), start (opens a frame in IDLE),
//        busy (in RUN), done (pulse after the last group), bus (byte in / group out).
module bytes_to_bits_stream
  import kyber_stream_pkg::*;
#(
  parameter int BYTE_LENGTH = DEFAULT_BYTE_LENGTH,
  parameter int OUT_W       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  bytes_to_bits_stream_if.slave bus
);

  localparam int N_GROUPS = (8 * BYTE_LENGTH) / OUT_W;
  localparam int BR_W     = $clog2(BYTE_LENGTH + 1);
  localparam int GS_W     = $clog2(N_GROUPS + 1);

  localparam logic [BR_W-1:0] BR_MAX  = BR_W'(BYTE_LENGTH);
  localparam logic [GS_W-1:0] GS_LAST = GS_W'(N_GROUPS - 1);
  localparam logic [4:0]      W5      = 5'(OUT_W);

  if (!out_w_legal(OUT_W, BYTE_LENGTH)) begin : g_bad_params
    $error("bytes_to_bits_stream: illegal OUT_W/BYTE_LENGTH combination");
  end

  state_t          state;
  logic [BR_W-1:0] bytes_rcvd;
  logic [GS_W-1:0] groups_sent;
  logic            done_q;

  logic [4:0]      cnt;
  logic            in_fire;
  logic            out_fire;
  logic            last_grp;
  logic            clear;

  assign busy          = (state == RUN);
  assign bus.in_ready  = busy && (bytes_rcvd < BR_MAX) && (cnt <= 5'd8);
  assign bus.out_valid = busy && (cnt >= W5);
  assign last_grp      = bus.out_valid && (groups_sent == GS_LAST);
  assign bus.out_last  = last_grp;
  assign done          = done_q;

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;
  assign clear    = (state == IDLE) && start;

  bit_accumulator #(
    .OUT_W (OUT_W)
  ) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear),
    .in_fire  (in_fire),
    .in_byte  (bus.in_byte),
    .out_fire (out_fire),
    .out_bits (bus.out_bits),
    .cnt      (cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      bytes_rcvd  <= '0;
      groups_sent <= '0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            bytes_rcvd  <= '0;
            groups_sent <= '0;
          end
        end
        RUN: begin
          // start is deliberately ignored here: a frame cannot be restarted.
          if (in_fire) bytes_rcvd <= bytes_rcvd + BR_W'(1);
          if (out_fire) begin
            groups_sent <= groups_sent + GS_W'(1);
            if (last_grp) begin
              state  <= IDLE;
              done_q <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bytes_to_bits_stream.sv
module tb_bytes_to_bits_stream;

  localparam int NCH = 4;

  function automatic int ch_w(input int g);
    case (g)
      0: return 1;
      1: return 8;
      2: return 3;
      default: return 1;
    endcase
  endfunction

  function automatic int ch_bl(input int g);
    case (g)
      0: return 2;
      1: return 32;
      2: return 3;
      default: return 32;
    endcase
  endfunction

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  logic            start_s [NCH];
  bit              in_stall [NCH];
  bit              out_stall [NCH];
  logic [7:0]      src_q [NCH][$];
  logic [8:0]      exp_q [NCH][$];
  int              acc_cnt [NCH];
  int              both_cnt [NCH];

  logic [NCH-1:0]  o_in_ready, o_out_valid, o_out_last, o_busy, o_done;
  logic [7:0]      o_bits [NCH];

  task automatic check(input string name, input bit ok, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    localparam int W  = ch_w(g);
    localparam int BL = ch_bl(g);

    bytes_to_bits_stream_if #(.OUT_W(W)) bus ();

    bytes_to_bits_stream #(
      .BYTE_LENGTH (BL),
      .OUT_W       (W)
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_s[g]),
      .busy  (o_busy[g]),
      .done  (o_done[g]),
      .bus   (bus)
    );

    assign o_in_ready[g]  = bus.in_ready;
    assign o_out_valid[g] = bus.out_valid;
    assign o_out_last[g]  = bus.out_last;
    assign o_bits[g]      = 8'(bus.out_bits);

    initial begin
      bus.in_valid  = 1'b0;
      bus.in_byte   = 8'h00;
      bus.out_ready = 1'b0;
      acc_cnt[g]    = 0;
      both_cnt[g]   = 0;
    end

    // Source: offers the head of src_q, pops it once the transfer happened.
    always begin : drv
      bit f;
      @(negedge clk);
      f = bus.in_valid && bus.in_ready;
      if (f) acc_cnt[g]++;
      if (f && bus.out_valid && bus.out_ready) both_cnt[g]++;
      @(posedge clk);
      #1;
      if (f && src_q[g].size() > 0) void'(src_q[g].pop_front());
      if (src_q[g].size() > 0 && (!in_stall[g] || $urandom_range(0, 1) == 1)) begin
        bus.in_valid = 1'b1;
        bus.in_byte  = src_q[g][0];
      end else begin
        bus.in_valid = 1'b0;
        bus.in_byte  = 8'($urandom);
      end
    end

    always @(posedge clk) begin
      #1;
      bus.out_ready = out_stall[g] ? ($urandom_range(0, 1) == 1) : 1'b1;
    end

    // Monitor: scoreboard pop on each output transfer, stall stability, done pulse.
    always @(negedge clk) begin : mon
      bit         held_v;
      logic [7:0] held_bits;
      bit         pend_done;
      logic [8:0] e;
      if (!rst_n) begin
        held_v    = 1'b0;
        pend_done = 1'b0;
      end else begin
        if (pend_done) begin
          check($sformatf("done_after_last_ch%0d", g), o_done[g] && !o_busy[g],
                {30'd0, o_done[g], o_busy[g]}, 32'h2);
          pend_done = 1'b0;
        end
        if (held_v) begin
          check($sformatf("stall_stable_ch%0d", g),
                bus.out_valid && (o_bits[g] == held_bits),
                {23'd0, bus.out_valid, o_bits[g]}, {23'd0, 1'b1, held_bits});
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q[g].size() == 0) begin
            check($sformatf("unexpected_group_ch%0d", g), 1'b0,
                  {23'd0, bus.out_last, o_bits[g]}, 32'h0);
          end else begin
            e = exp_q[g].pop_front();
            check($sformatf("group_ch%0d", g), {bus.out_last, o_bits[g]} == e,
                  {23'd0, bus.out_last, o_bits[g]}, {23'd0, e});
          end
          if (bus.out_last) pend_done = 1'b1;
        end
        held_v    = bus.out_valid && !bus.out_ready;
        held_bits = o_bits[g];
      end
    end
  end

  task automatic exp_byte_bits(input int ch, input logic [7:0] b, input bit last_byte);
    for (int i = 0; i < 8; i++)
      exp_q[ch].push_back({last_byte && (i == 7), 7'd0, b[i]});
  endtask

  task automatic pulse_start(input int ch, output int t0);
    @(posedge clk);
    #2;
    start_s[ch] = 1'b1;
    t0 = cyc;
    @(posedge clk);
    #2;
    start_s[ch] = 1'b0;
  endtask

  // Returns at the falling edge of the cycle in which done is seen.
  task automatic wait_done(input int ch, input int t0, input int max, output int el);
    int n;
    el = -1;
    n  = 0;
    while (el < 0 && n < max) begin
      @(negedge clk);
      if (o_done[ch]) el = cyc - t0;
      n++;
    end
    if (el < 0) check($sformatf("done_timeout_ch%0d", ch), 1'b0, 32'(n), 32'(max));
  endtask

  bit         basic_bits [16] = '{1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0};
  logic [2:0] w3_groups [8]   = '{3'd2,3'd3,3'd5,3'd1,3'd4,3'd5,3'd5,3'd4};

  initial begin
    int t0, ts, el, a0, b0;
    for (int c = 0; c < NCH; c++) begin
      start_s[c]   = 1'b0;
      in_stall[c]  = 1'b0;
      out_stall[c] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    for (int c = 0; c < NCH; c++)
      check($sformatf("reset_outputs_ch%0d", c),
            {o_in_ready[c], o_out_valid[c], o_out_last[c], o_busy[c], o_done[c], o_bits[c]} == 13'd0,
            {19'd0, o_in_ready[c], o_out_valid[c], o_out_last[c], o_busy[c], o_done[c], o_bits[c]}, 32'd0);
    rst_n = 1'b1;

    // Basic frame: OUT_W=1, two bytes, hand-listed bit order.
    src_q[0].push_back(8'hA5);
    src_q[0].push_back(8'h3C);
    for (int i = 0; i < 16; i++) exp_q[0].push_back({(i == 15), 7'd0, basic_bits[i]});
    pulse_start(0, t0);
    check("in_ready_after_start_ch0", o_in_ready[0] == 1'b1, 32'(o_in_ready[0]), 32'd1);
    wait_done(0, t0, 100, el);
    check("basic_done_cycle", el == 18, 32'(el), 32'd18);

    // Full rate OUT_W=8, plus extra bytes after the frame and a start pulse mid-frame.
    for (int i = 0; i < 32; i++) begin
      src_q[1].push_back(8'(i));
      exp_q[1].push_back({(i == 31), 8'(i)});
    end
    for (int i = 0; i < 4; i++) src_q[1].push_back(8'hEE);
    a0 = acc_cnt[1];
    b0 = both_cnt[1];
    pulse_start(1, t0);
    repeat (8) @(posedge clk);
    #2;
    check("busy_before_midframe_start", o_busy[1] == 1'b1, 32'(o_busy[1]), 32'd1);
    start_s[1] = 1'b1;
    @(posedge clk);
    #2;
    start_s[1] = 1'b0;
    wait_done(1, t0, 100, el);
    check("fullrate_done_cycle", el == 34, 32'(el), 32'd34);
    check("fullrate_both_fire_cycles", both_cnt[1] - b0 == 31, 32'(both_cnt[1] - b0), 32'd31);
    check("fullrate_bytes_accepted", acc_cnt[1] - a0 == 32, 32'(acc_cnt[1] - a0), 32'd32);
    check("extra_bytes_not_taken", src_q[1].size() == 4, 32'(src_q[1].size()), 32'd4);
    check("in_ready_low_after_frame", o_in_ready[1] == 1'b0, 32'(o_in_ready[1]), 32'd0);

    // Random stalls, OUT_W=3, bytes 5A C3 96.
    in_stall[2]  = 1'b1;
    out_stall[2] = 1'b1;
    src_q[2].push_back(8'h5A);
    src_q[2].push_back(8'hC3);
    src_q[2].push_back(8'h96);
    for (int i = 0; i < 8; i++) exp_q[2].push_back({(i == 7), 5'd0, w3_groups[i]});
    pulse_start(2, t0);
    wait_done(2, t0, 1000, el);
    in_stall[2]  = 1'b0;
    out_stall[2] = 1'b0;

    // Reset mid-frame after 5 of 32 bytes.
    for (int i = 0; i < 32; i++) begin
      src_q[3].push_back(8'(i * 7 + 1));
      exp_byte_bits(3, 8'(i * 7 + 1), i == 31);
    end
    a0 = acc_cnt[3];
    pulse_start(3, t0);
    el = 0;
    while (acc_cnt[3] - a0 < 5 && el < 200) begin
      @(negedge clk);
      el++;
    end
    check("five_bytes_before_reset", acc_cnt[3] - a0 == 5, 32'(acc_cnt[3] - a0), 32'd5);
    @(posedge clk);
    #2;
    check("busy_before_reset", o_busy[3] == 1'b1, 32'(o_busy[3]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {o_in_ready[3], o_out_valid[3], o_out_last[3], o_busy[3], o_done[3], o_bits[3]} == 13'd0,
          {19'd0, o_in_ready[3], o_out_valid[3], o_out_last[3], o_busy[3], o_done[3], o_bits[3]}, 32'd0);
    src_q[3].delete();
    exp_q[3].delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;

    // Fresh frame, then a back-to-back frame started in the done cycle.
    for (int i = 0; i < 32; i++) begin
      src_q[3].push_back(8'(i * 37 + 11));
      exp_byte_bits(3, 8'(i * 37 + 11), i == 31);
    end
    for (int i = 0; i < 32; i++) begin
      src_q[3].push_back(8'(255 - i));
      exp_byte_bits(3, 8'(255 - i), i == 31);
    end
    pulse_start(3, t0);
    wait_done(3, t0, 400, el);
    check("w1_frame_done_cycle", el == 258, 32'(el), 32'd258);
    start_s[3] = 1'b1;
    ts = cyc;
    @(posedge clk);
    #2;
    start_s[3] = 1'b0;
    check("b2b_no_group_at_plus1", o_out_valid[3] == 1'b0, 32'(o_out_valid[3]), 32'd0);
    @(posedge clk);
    #2;
    check("b2b_group_at_plus2", o_out_valid[3] == 1'b1, 32'(o_out_valid[3]), 32'd1);
    wait_done(3, ts, 400, el);
    check("b2b_done_cycle", el == 258, 32'(el), 32'd258);

    repeat (3) @(posedge clk);
    for (int c = 0; c < NCH; c++)
      check($sformatf("scoreboard_drained_ch%0d", c), exp_q[c].size() == 0, 32'(exp_q[c].size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
